// File: rtl/huffman_decoder.sv
// Bit-serial Huffman decoder: consumes 32-bit words LSB-first, matches prefixes
// against a programmable code table and emits symbols over valid/ready.
module huffman_decoder #(
   parameter int unsigned NSYM  = 16,
   parameter int unsigned SYM_W = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             tbl_we,
   input  logic [3:0]       tbl_addr,
   input  logic [7:0]       tbl_code,
   input  logic [3:0]       tbl_length,
   input  logic [SYM_W-1:0] tbl_symbol,
   input  logic [31:0]      word_in,
   input  logic [5:0]       word_len,
   input  logic             word_valid,
   output logic             word_ready,
   output logic [SYM_W-1:0] symbol_out,
   output logic             symbol_valid,
   input  logic             symbol_ready,
   output logic             error,
   output logic             busy
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BL_W   = 6;
   localparam int unsigned CODE_W = 8;
   localparam int unsigned LEN_W  = 4;

   typedef enum logic [1:0] {S_EMPTY, S_DECODE, S_ERROR} state_t;

   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic [LEN_W-1:0]  length;
      logic [SYM_W-1:0]  symbol;
   } entry_t;

   state_t              state, state_d;
   logic [WORD_W-1:0]   sh, sh_d;
   logic [BL_W-1:0]     bl, bl_d;
   logic [CODE_W-1:0]   cand, cand_d;
   logic [LEN_W-1:0]    cand_len, cand_len_d;
   logic [SYM_W-1:0]    symbol_d;
   logic                symbol_valid_d;
   logic                error_d;
   entry_t              tbl [NSYM];

   logic [CODE_W-1:0]   new_cand;
   logic [LEN_W-1:0]    new_len;
   logic [CODE_W-1:0]   mask;
   logic                hit;
   logic [SYM_W-1:0]    hit_sym;
   logic                miss_full;
   logic                advance;
   logic [BL_W-1:0]     len_sat;

   // Code table; a lookup in the same cycle as a write sees the old entry
   always_ff @(posedge clock) begin
      if (!resetn) begin
         for (int i = 0; i < int'(NSYM); i++) tbl[i] <= '0;
      end else if (tbl_we) begin
         tbl[tbl_addr] <= '{code: tbl_code, length: tbl_length, symbol: tbl_symbol};
      end
   end

   // Candidate extended by the next stream bit, matched against the table (lowest index wins)
   always_comb begin
      new_cand = cand;
      new_cand[cand_len[2:0]] = sh[0];
      new_len  = cand_len + LEN_W'(1);
      mask     = CODE_W'((9'd1 << new_len) - 9'd1);
      hit      = 1'b0;
      hit_sym  = '0;
      for (int i = 0; i < int'(NSYM); i++) begin
         if (!hit && tbl[i].length == new_len && ((tbl[i].code ^ new_cand) & mask) == '0) begin
            hit     = 1'b1;
            hit_sym = tbl[i].symbol;
         end
      end
      miss_full = !hit && (new_len == LEN_W'(8));
   end

   assign len_sat = (word_len > BL_W'(32)) ? BL_W'(32) : word_len;
   assign advance = !symbol_valid || symbol_ready;

   always_comb begin
      state_d        = state;
      sh_d           = sh;
      bl_d           = bl;
      cand_d         = cand;
      cand_len_d     = cand_len;
      symbol_d       = symbol_out;
      symbol_valid_d = symbol_valid && !symbol_ready;
      error_d        = error;
      case (state)
         S_EMPTY: begin
            if (word_valid) begin
               sh_d = word_in;
               bl_d = len_sat;
               if (len_sat != '0) state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (advance) begin
               sh_d = {1'b0, sh[WORD_W-1:1]};
               bl_d = bl - BL_W'(1);
               if (hit) begin
                  symbol_d       = hit_sym;
                  symbol_valid_d = 1'b1;
                  cand_d         = '0;
                  cand_len_d     = '0;
               end else begin
                  cand_d     = new_cand;
                  cand_len_d = new_len;
               end
               if (miss_full) begin
                  error_d = 1'b1;
                  state_d = S_ERROR;
               end else if (bl == BL_W'(1)) begin
                  state_d = S_EMPTY;
               end
            end
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: state_d = S_EMPTY;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state        <= S_EMPTY;
         sh           <= '0;
         bl           <= '0;
         cand         <= '0;
         cand_len     <= '0;
         symbol_out   <= '0;
         symbol_valid <= 1'b0;
         error        <= 1'b0;
      end else begin
         state        <= state_d;
         sh           <= sh_d;
         bl           <= bl_d;
         cand         <= cand_d;
         cand_len     <= cand_len_d;
         symbol_out   <= symbol_d;
         symbol_valid <= symbol_valid_d;
         error        <= error_d;
      end
   end

   assign word_ready = (state == S_EMPTY);
   assign busy       = (state == S_DECODE) || (cand_len != '0);

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: directed timing checks plus randomized
// prefix-code streams compared against a bit-level reference decoder.
module tb_huffman_decoder;

   logic        clock = 1'b0;
   logic        resetn;
   logic        tbl_we;
   logic [3:0]  tbl_addr;
   logic [7:0]  tbl_code;
   logic [3:0]  tbl_length;
   logic [7:0]  tbl_symbol;
   logic [31:0] word_in;
   logic [5:0]  word_len;
   logic        word_valid;
   logic        word_ready;
   logic [7:0]  symbol_out;
   logic        symbol_valid;
   logic        symbol_ready;
   logic        error;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;
   int got[$];
   int exp_q[$];
   int mcode[16];
   int mlen[16];
   int msym[16];
   int mcv, mcl;
   bit merr;
   bit rnd_ready;

   huffman_decoder #(.NSYM(16), .SYM_W(8)) dut (
      .clock(clock), .resetn(resetn),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code),
      .tbl_length(tbl_length), .tbl_symbol(tbl_symbol),
      .word_in(word_in), .word_len(word_len), .word_valid(word_valid),
      .word_ready(word_ready), .symbol_out(symbol_out),
      .symbol_valid(symbol_valid), .symbol_ready(symbol_ready),
      .error(error), .busy(busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock)
      if (resetn && symbol_valid && symbol_ready) got.push_back(int'(symbol_out));

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_checks++;
      if (obs !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, req);
      end
   endtask

   // Reference: grow the candidate bit string, emit the first table entry whose code equals it
   task automatic model_bit(input int b);
      if (merr) return;
      mcv = mcv | (b << mcl);
      mcl++;
      for (int i = 0; i < 16; i++) begin
         if (mlen[i] == mcl && ((mcode[i] ^ mcv) & ((1 << mcl) - 1)) == 0) begin
            exp_q.push_back(msym[i]);
            mcv = 0;
            mcl = 0;
            return;
         end
      end
      if (mcl == 8) merr = 1'b1;
   endtask

   task automatic model_word(input logic [31:0] w, input int len);
      int n;
      n = (len > 32) ? 32 : len;
      for (int i = 0; i < n; i++) model_bit(int'(w[i]));
   endtask

   task automatic do_reset();
      resetn = 1'b0; tbl_we = 1'b0; word_valid = 1'b0;
      @(posedge clock); @(posedge clock);
      @(negedge clock);
      chk("rst_word_ready", 32'(word_ready), 32'd1);
      chk("rst_symbol_valid", 32'(symbol_valid), 32'd0);
      chk("rst_symbol_out", 32'(symbol_out), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      resetn = 1'b1;
      got.delete(); exp_q.delete();
      for (int i = 0; i < 16; i++) begin mcode[i] = 0; mlen[i] = 0; msym[i] = 0; end
      mcv = 0; mcl = 0; merr = 1'b0;
   endtask

   task automatic write_tbl(input int a, input int code, input int len, input int sym);
      tbl_we = 1'b1; tbl_addr = 4'(a); tbl_code = 8'(code);
      tbl_length = 4'(len); tbl_symbol = 8'(sym);
      @(posedge clock);
      @(negedge clock);
      tbl_we = 1'b0;
      mcode[a] = code; mlen[a] = len; msym[a] = sym;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (rnd_ready) symbol_ready = 1'($urandom_range(0, 1));
      end
   endtask

   // Returns half a cycle after the accepting edge
   task automatic send_word(input logic [31:0] w, input int len);
      int cyc;
      cyc = 0;
      while (!word_ready && cyc < 2000) begin step(1); cyc++; end
      if (!word_ready) chk("word_ready_timeout", 32'd0, 32'd1);
      word_in = w; word_len = 6'(len); word_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      word_valid = 1'b0;
      model_word(w, len);
   endtask

   task automatic drain_compare(input string tag);
      int cyc;
      symbol_ready = 1'b1;
      rnd_ready = 1'b0;
      cyc = 0;
      while (!((word_ready || error) && !symbol_valid) && cyc < 300) begin step(1); cyc++; end
      if (cyc >= 300) chk({tag, "_drain_timeout"}, 32'd0, 32'd1);
      chk({tag, "_nsym"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_sym%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
      chk({tag, "_error"}, 32'(error), 32'(merr));
      got.delete(); exp_q.delete();
   endtask

   task automatic load_table_a();
      write_tbl(0, 'b0, 1, 'h41);
      write_tbl(1, 'b01, 2, 'h42);
      write_tbl(2, 'b11, 2, 'h43);
   endtask

   // Complete prefix code built by random leaf splitting, scattered over random indices
   task automatic load_random_table();
      int lc[16]; int ll[16]; int perm[16];
      int n, tgt, k, j, t;
      lc[0] = 0; ll[0] = 0; n = 1;
      tgt = $urandom_range(2, 16);
      while (n < tgt) begin
         k = $urandom_range(0, n - 1);
         if (ll[k] >= 8)
            for (j = 0; j < n; j++) if (ll[j] < 8) begin k = j; break; end
         lc[n] = lc[k] | (1 << ll[k]);
         ll[n] = ll[k] + 1;
         ll[k] = ll[k] + 1;
         n++;
      end
      for (int i = 0; i < 16; i++) perm[i] = i;
      for (int i = 15; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < n; i++) write_tbl(perm[i], lc[i], ll[i], $urandom_range(0, 255));
   endtask

   initial begin
      resetn = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_length = '0;
      tbl_symbol = '0; word_in = '0; word_len = '0; word_valid = 1'b0;
      symbol_ready = 1'b1; rnd_ready = 1'b0;
      @(negedge clock);
      do_reset();

      // Basic stream with latency and word_ready return
      load_table_a();
      send_word(32'h0000000E, 5);
      chk("t1_ready_low", 32'(word_ready), 32'd0);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_sv_early", 32'(symbol_valid), 32'd0);
      step(1);
      chk("t1_sv_first", 32'(symbol_valid), 32'd1);
      chk("t1_sym_first", 32'(symbol_out), 32'h41);
      step(3);
      chk("t1_ready_t4", 32'(word_ready), 32'd0);
      step(1);
      chk("t1_ready_t5", 32'(word_ready), 32'd1);
      drain_compare("t1");

      // Code spanning two one-bit words
      send_word(32'h1, 1);
      step(1);
      chk("t2_ready_between", 32'(word_ready), 32'd1);
      chk("t2_busy_between", 32'(busy), 32'd1);
      chk("t2_sv_between", 32'(symbol_valid), 32'd0);
      send_word(32'h1, 1);
      step(1);
      chk("t2_sv", 32'(symbol_valid), 32'd1);
      chk("t2_sym", 32'(symbol_out), 32'h43);
      drain_compare("t2");

      // Backpressure holds the first symbol
      symbol_ready = 1'b0;
      send_word(32'h0000000E, 5);
      step(1);
      for (int i = 0; i < 10; i++) begin
         chk("t3_hold_sv", 32'(symbol_valid), 32'd1);
         chk("t3_hold_sym", 32'(symbol_out), 32'h41);
         step(1);
      end
      chk("t3_ready_stalled", 32'(word_ready), 32'd0);
      drain_compare("t3");

      // No match within 8 bits
      do_reset();
      write_tbl(5, 'hFF, 8, 'h77);
      send_word(32'h0, 32);
      step(7);
      chk("t4_err_t7", 32'(error), 32'd0);
      step(1);
      chk("t4_err_t8", 32'(error), 32'd1);
      chk("t4_ready", 32'(word_ready), 32'd0);
      step(5);
      chk("t4_err_sticky", 32'(error), 32'd1);
      chk("t4_ready_sticky", 32'(word_ready), 32'd0);
      drain_compare("t4");
      do_reset();

      // Full words, saturated length and empty word
      write_tbl(3, 'hA5, 8, 'h5A);
      for (int r = 0; r < 2; r++) begin
         send_word(32'hA5A5A5A5, (r == 0) ? 32 : 40);
         step(31);
         chk("t5_ready_t31", 32'(word_ready), 32'd0);
         step(1);
         chk("t5_ready_t32", 32'(word_ready), 32'd1);
         drain_compare(r == 0 ? "t5_len32" : "t5_len40");
      end
      send_word(32'hA5A5A5A5, 0);
      chk("t5_len0_ready", 32'(word_ready), 32'd1);
      chk("t5_len0_busy", 32'(busy), 32'd0);
      drain_compare("t5_len0");

      // Reset mid-word wipes the table
      send_word(32'h0, 32);
      step(3);
      do_reset();
      send_word(32'h0, 32);
      step(7);
      chk("t6_err_t7", 32'(error), 32'd0);
      step(1);
      chk("t6_err_t8", 32'(error), 32'd1);
      drain_compare("t6");

      // Randomized tables, word lengths and consumer stalls
      for (int r = 0; r < 4; r++) begin
         do_reset();
         load_random_table();
         rnd_ready = 1'b1;
         for (int w = 0; w < 30; w++) send_word($urandom, $urandom_range(0, 40));
         drain_compare($sformatf("rnd%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
